// File: rtl/uart_tx_scheduler.sv
// Two-requester UART transmitter: round-robin arbitration at frame boundaries,
// one bit per baud tick, back-to-back frames when a request is waiting.
module uart_tx_scheduler #(
    parameter int unsigned DATA_BITS = 8,
    parameter int unsigned STOP_BITS = 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 i_Baud_Tick,
    input  logic [1:0]           i_Req,
    input  logic [DATA_BITS-1:0] i_Data0,
    input  logic [DATA_BITS-1:0] i_Data1,
    output logic [1:0]           o_Grant,
    output logic                 o_Tx,
    output logic                 o_Busy,
    output logic                 o_Done
);
    localparam int unsigned CntW = $clog2(DATA_BITS + 1);
    localparam logic [CntW-1:0] LastBit = CntW'(DATA_BITS - 1);
    // STOP_BITS is 1 or 2, so a single bit counts stop periods.
    localparam logic LastStop = 1'(STOP_BITS - 1);

    typedef enum logic [1:0] {StIdle, StStart, StData, StStop} state_e;

    state_e               state_q, state_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic [CntW-1:0]      bit_cnt_q, bit_cnt_d;
    logic                 stop_cnt_q, stop_cnt_d;
    logic                 ptr_q, ptr_d;
    logic                 tx_q, tx_d;
    logic [1:0]           grant_q, grant_d;
    logic                 done_q, done_d;
    logic                 last_stop;
    logic                 arb_en;
    logic                 pick;

    always_comb begin
        state_d    = state_q;
        shift_d    = shift_q;
        bit_cnt_d  = bit_cnt_q;
        stop_cnt_d = stop_cnt_q;
        ptr_d      = ptr_q;
        grant_d    = 2'b00;
        done_d     = 1'b0;
        last_stop  = (state_q == StStop) && (stop_cnt_q == LastStop);
        arb_en     = i_Baud_Tick && ((state_q == StIdle) || last_stop);
        // ptr_q holds the last grantee; on contention the other one wins.
        pick       = i_Req[1] && (!i_Req[0] || !ptr_q);

        if (i_Baud_Tick) begin
            unique case (state_q)
                StIdle: ;
                StStart: begin
                    state_d   = StData;
                    bit_cnt_d = '0;
                end
                StData: begin
                    shift_d   = shift_q >> 1;
                    bit_cnt_d = bit_cnt_q + 1'b1;
                    if (bit_cnt_q == LastBit) begin
                        state_d    = StStop;
                        stop_cnt_d = 1'b0;
                    end
                end
                StStop: begin
                    if (last_stop) begin
                        done_d  = 1'b1;
                        state_d = StIdle;
                    end else begin
                        stop_cnt_d = stop_cnt_q + 1'b1;
                    end
                end
                default: state_d = StIdle;
            endcase

            if (arb_en && (i_Req != 2'b00)) begin
                grant_d = pick ? 2'b10 : 2'b01;
                shift_d = pick ? i_Data1 : i_Data0;
                ptr_d   = pick;
                state_d = StStart;
            end
        end

        case (state_d)
            StStart: tx_d = 1'b0;
            StData:  tx_d = shift_d[0];
            default: tx_d = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= StIdle;
            shift_q    <= '0;
            bit_cnt_q  <= '0;
            stop_cnt_q <= 1'b0;
            ptr_q      <= 1'b1;
            tx_q       <= 1'b1;
            grant_q    <= 2'b00;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            shift_q    <= shift_d;
            bit_cnt_q  <= bit_cnt_d;
            stop_cnt_q <= stop_cnt_d;
            ptr_q      <= ptr_d;
            tx_q       <= tx_d;
            grant_q    <= grant_d;
            done_q     <= done_d;
        end
    end

    assign o_Tx    = tx_q;
    assign o_Grant = grant_q;
    assign o_Done  = done_q;
    assign o_Busy  = (state_q != StIdle);

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// Scoreboard bench: a tick-counting frame model predicts grants and payloads,
// a monitor deserialises o_Tx and compares against the queued expectations.
module tb_uart_tx_scheduler;
    localparam int D   = 8;
    localparam int NB1 = 1 + D + 1;

    typedef struct packed {
        logic [1:0]   grant;
        logic [D-1:0] data;
    } exp_t;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         tick = 1'b0;
    logic [1:0]   req = 2'b00;
    logic [D-1:0] data0 = '0;
    logic [D-1:0] data1 = '0;
    logic [1:0]   grant;
    logic         tx, busy, done;

    logic [1:0]   req2 = 2'b00;
    logic [D-1:0] data2 = '0;
    logic [1:0]   grant2;
    logic         tx2, busy2, done2;

    logic [1:0]   nreq = 2'b00;
    logic [D-1:0] nd0 = '0, nd1 = '0;
    logic [1:0]   nreq2 = 2'b00;
    logic [D-1:0] nd2 = '0;

    int errors = 0;
    int checks = 0;

    // Reference model state
    bit m_busy = 1'b0;
    int m_left = 0;
    int m_last = 1;
    exp_t exp_q[$];

    // Monitor state
    bit prev_rst = 1'b0;
    bit prev_tick = 1'b0;
    bit in_frame = 1'b0;
    int idx = 0;
    bit exp_bits [0:15];

    always #5 clk = ~clk;

    uart_tx_scheduler #(.DATA_BITS(D), .STOP_BITS(1)) dut (
        .clk(clk), .reset(reset), .i_Baud_Tick(tick), .i_Req(req),
        .i_Data0(data0), .i_Data1(data1), .o_Grant(grant), .o_Tx(tx),
        .o_Busy(busy), .o_Done(done)
    );

    uart_tx_scheduler #(.DATA_BITS(D), .STOP_BITS(2)) dut2 (
        .clk(clk), .reset(reset), .i_Baud_Tick(tick), .i_Req(req2),
        .i_Data0(data2), .i_Data1(data2), .o_Grant(grant2), .o_Tx(tx2),
        .o_Busy(busy2), .o_Done(done2)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, expv, $time);
        end
    endtask

    // Applies staged inputs for one cycle and advances the model at the edge
    // that will sample them.
    task automatic step(input bit t, input bit rst, input bit hold);
        int g;
        exp_t e;
        @(posedge clk);
        #1;
        tick  = t;
        reset = rst;
        req   = nreq;
        data0 = nd0;
        data1 = nd1;
        req2  = nreq2;
        data2 = nd2;
        if (rst) begin
            m_busy = 1'b0;
            m_left = 0;
            m_last = 1;
        end else if (t) begin
            if (!m_busy || m_left == 1) begin
                m_busy = 1'b0;
                if (req != 2'b00) begin
                    if (req == 2'b01)      g = 0;
                    else if (req == 2'b10) g = 1;
                    else                   g = (m_last == 1) ? 0 : 1;
                    e.grant = (g == 1) ? 2'b10 : 2'b01;
                    e.data  = (g == 1) ? data1 : data0;
                    exp_q.push_back(e);
                    m_last = g;
                    m_busy = 1'b1;
                    m_left = NB1;
                    if (!hold) nreq[g] = 1'b0;
                end
            end else begin
                m_left--;
            end
        end
    endtask

    always @(negedge clk) begin
        bit   done_exp;
        exp_t e;
        if (prev_rst) begin
            chk("rst_tx", {31'b0, tx}, 1);
            chk("rst_busy", {31'b0, busy}, 0);
            chk("rst_grant", {30'b0, grant}, 0);
            chk("rst_done", {31'b0, done}, 0);
            in_frame = 1'b0;
        end else begin
            done_exp = 1'b0;
            if (prev_tick && in_frame) begin
                if (idx == NB1) begin
                    done_exp = 1'b1;
                    in_frame = 1'b0;
                end else begin
                    chk("tx_bit", {31'b0, tx}, {31'b0, exp_bits[idx]});
                    idx++;
                end
            end
            chk("done", {31'b0, done}, {31'b0, done_exp});
            if (grant != 2'b00) begin
                if (exp_q.size() == 0) begin
                    chk("grant_unexpected", {30'b0, grant}, 0);
                end else begin
                    e = exp_q.pop_front();
                    chk("grant", {30'b0, grant}, {30'b0, e.grant});
                    exp_bits[0] = 1'b0;
                    for (int i = 0; i < D; i++) exp_bits[1 + i] = e.data[i];
                    exp_bits[NB1 - 1] = 1'b1;
                    chk("start_bit", {31'b0, tx}, 0);
                    in_frame = 1'b1;
                    idx = 1;
                end
            end
            chk("busy", {31'b0, busy}, {31'b0, in_frame});
            if (!in_frame) chk("idle_tx", {31'b0, tx}, 1);
        end
        prev_rst  = reset;
        prev_tick = tick;
    end

    // Two-stop-bit instance: 0xFF frame spans 11 ticks, low only for the start bit.
    initial begin : s2_check
        int hi, lo, nt, n;
        bit got, fin;
        got = 1'b0; fin = 1'b0; hi = 0; lo = 0; nt = 0;
        for (n = 0; n < 400 && !got; n++) begin
            @(negedge clk);
            got = (grant2 == 2'b01);
        end
        chk("s2_grant", {31'b0, got}, 1);
        for (n = 0; n < 400 && !fin; n++) begin
            if (busy2) begin
                if (tx2) hi++;
                else     lo++;
            end
            if (tick) nt++;
            @(negedge clk);
            fin = done2;
        end
        chk("s2_done_seen", {31'b0, fin}, 1);
        chk("s2_ticks", nt, 11);
        chk("s2_low_cycles", lo, 16);
        chk("s2_high_cycles", hi, 160);
        chk("s2_busy_after", {31'b0, busy2}, 0);
        chk("s2_tx_after", {31'b0, tx2}, 1);
    end

    initial begin
        repeat (3) step(1'b0, 1'b1, 1'b0);

        // Single request 0xA5, tick every 16 clocks
        nd0 = 8'hA5; nreq = 2'b01;
        nd2 = 8'hFF; nreq2 = 2'b01;
        for (int c = 0; c < 16 * 13; c++) begin
            step((c % 16) == 0, 1'b0, 1'b0);
            nreq2 = 2'b00;
        end

        // Contention from reset, both requests held
        step(1'b0, 1'b1, 1'b1);
        nd0 = 8'h11; nd1 = 8'h22; nreq = 2'b11;
        for (int c = 0; c < 16 * 40; c++) step((c % 16) == 0, 1'b0, 1'b1);
        nreq = 2'b00;
        for (int c = 0; c < 16 * 12; c++) step((c % 16) == 0, 1'b0, 1'b0);

        // Request withdrawn between ticks
        for (int c = 0; c < 64; c++) begin
            nreq = (c >= 2 && c < 5) ? 2'b01 : 2'b00;
            step((c % 16) == 0, 1'b0, 1'b0);
        end

        // Reset during the 4th data bit, then contention
        nd0 = 8'h3C; nd1 = 8'hC3; nreq = 2'b01;
        for (int c = 0; c < 16 * 30; c++) begin
            if (c == 71) nreq = 2'b11;
            step((c % 16) == 0, c == 70, 1'b0);
        end

        // Randomised traffic: irregular ticks, withdrawals, data churn, rare resets
        for (int c = 0; c < 4000; c++) begin
            nd0 = 8'($urandom);
            nd1 = 8'($urandom);
            for (int b = 0; b < 2; b++) begin
                if (!nreq[b]) nreq[b] = ($urandom_range(19) == 0);
                else if ($urandom_range(49) == 0) nreq[b] = 1'b0;
            end
            step($urandom_range(3) == 0, $urandom_range(999) == 0, 1'b0);
        end

        nreq = 2'b00;
        for (int c = 0; c < 300; c++) step((c % 4) == 0, 1'b0, 1'b0);
        @(negedge clk);
        chk("queue_drained", exp_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
